// File: rtl/bus_pkg.sv
// Shared encodings for the lab bus sequencer: opcodes, bus sources,
// FSM states and the idle control word.
package bus_pkg;

  localparam int ADDR_W_DEF = 4;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LDEXT = 3'd1;
  localparam logic [2:0] OP_MOV   = 3'd2;
  localparam logic [2:0] OP_ST    = 3'd3;
  localparam logic [2:0] OP_LD    = 3'd4;
  localparam logic [2:0] OP_BCOPY = 3'd5;

  localparam logic [1:0] SEL_R1  = 2'd0;
  localparam logic [1:0] SEL_R2  = 2'd1;
  localparam logic [1:0] SEL_R3  = 2'd2;
  localparam logic [1:0] SEL_RAM = 2'd3;

  localparam logic [2:0] REN_R1 = 3'b001;
  localparam logic [2:0] REN_R2 = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    BC_RD,
    BC_WR,
    FIN
  } state_t;

  typedef struct packed {
    logic [1:0] bus_sel;
    logic       in_sel;
    logic [2:0] reg_en;
    logic       ram_wen;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic [2:0] onehot(input logic [1:0] d);
    onehot = 3'b001 << d;
  endfunction

endpackage

// File: rtl/bus_seq_ctrl.sv
// Command sequencer for the R1-R3 / RAM lab datapath. Drives all
// mux selects and enables cycle by cycle from one latched command.
module bus_seq_ctrl
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [1:0]        cmd_dst,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_addr2,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic [1:0]        bus_sel,
  output logic              in_sel,
  output logic [2:0]        reg_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  ctrl_t             ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr2_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic              rej_q;

  logic is_mov;
  logic is_ld;
  logic is_bcopy;
  logic bad;
  logic dst_r1;
  logic last;

  always_comb begin
    is_mov   = cmd_op == OP_MOV;
    is_ld    = cmd_op == OP_LD;
    is_bcopy = cmd_op == OP_BCOPY;
    dst_r1   = cmd_dst == SEL_R1;
    bad      = 1'b0;
    unique case (1'b1)
      cmd_op > OP_BCOPY:  bad = 1'b1;
      is_mov || is_ld:    bad = cmd_dst == 2'd3;
      is_bcopy:           bad = cmd_len == '0;
      default:            bad = 1'b0;
    endcase
    last = idx == len_q - ONE;
  end

  assign bus_sel = ctrl_q.bus_sel;
  assign in_sel  = ctrl_q.in_sel;
  assign reg_en  = ctrl_q.reg_en;
  assign ram_wen = ctrl_q.ram_wen;

  // Outputs are set on the edge that enters the state they belong to,
  // so every control is registered and the default below is "idle".
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      ctrl_q    <= CTRL_IDLE;
      ram_addr  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      addr_q    <= '0;
      addr2_q   <= '0;
      len_q     <= '0;
      idx       <= '0;
      rej_q     <= 1'b0;
    end else begin
      ctrl_q   <= CTRL_IDLE;
      ram_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            addr2_q   <= cmd_addr2;
            len_q     <= cmd_len;
            idx       <= '0;
            rej_q     <= bad;
            if (is_bcopy && !bad) begin
              state          <= BC_RD;
              ctrl_q.bus_sel <= SEL_RAM;
              ctrl_q.reg_en  <= REN_R2;
              ram_addr       <= cmd_addr;
            end else begin
              // Rejected and NOP commands spend an idle EXEC cycle
              state <= EXEC;
              if (!bad) begin
                unique case (cmd_op)
                  OP_LDEXT: begin
                    ctrl_q.reg_en <= REN_R1;
                  end
                  OP_MOV: begin
                    ctrl_q.bus_sel <= cmd_src;
                    ctrl_q.reg_en  <= onehot(cmd_dst);
                    ctrl_q.in_sel  <= dst_r1;
                    if (cmd_src == SEL_RAM)
                      ram_addr <= cmd_addr;
                  end
                  OP_ST: begin
                    ctrl_q.bus_sel <= cmd_src;
                    ctrl_q.ram_wen <= 1'b1;
                    ram_addr       <= cmd_addr;
                  end
                  OP_LD: begin
                    ctrl_q.bus_sel <= SEL_RAM;
                    ctrl_q.reg_en  <= onehot(cmd_dst);
                    ctrl_q.in_sel  <= dst_r1;
                    ram_addr       <= cmd_addr;
                  end
                  default: ;
                endcase
              end
            end
          end
        end
        EXEC: begin
          state <= FIN;
          done  <= 1'b1;
          err   <= rej_q;
        end
        BC_RD: begin
          state          <= BC_WR;
          ctrl_q.bus_sel <= SEL_R2;
          ctrl_q.ram_wen <= 1'b1;
          ram_addr       <= addr2_q + idx;
        end
        BC_WR: begin
          if (last) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            state          <= BC_RD;
            idx            <= idx + ONE;
            ctrl_q.bus_sel <= SEL_RAM;
            ctrl_q.reg_en  <= REN_R2;
            ram_addr       <= addr_q + idx + ONE;
          end
        end
        FIN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// Bench for bus_seq_ctrl: lab datapath model, command-level schedule
// model compared every cycle, plus hand-computed register/RAM checks.
module tb_bus_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_src;
  logic [1:0] cmd_dst;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_addr2;
  logic [3:0] cmd_len;
  logic [1:0] bus_sel;
  logic       in_sel;
  logic [2:0] reg_en;
  logic       ram_wen;
  logic [3:0] ram_addr;
  logic       done;
  logic       err;

  bus_seq_ctrl #(.ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
    .cmd_addr(cmd_addr), .cmd_addr2(cmd_addr2), .cmd_len(cmd_len),
    .bus_sel(bus_sel), .in_sel(in_sel), .reg_en(reg_en),
    .ram_wen(ram_wen), .ram_addr(ram_addr),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Lab datapath driven by the controller
  logic       dp_init;
  logic [3:0] sw;
  logic [3:0] r1, r2, r3;
  logic [3:0] ram [16];
  logic [3:0] bus;

  always_comb begin
    case (bus_sel)
      2'd0: bus = r1;
      2'd1: bus = r2;
      2'd2: bus = r3;
      default: bus = ram[ram_addr];
    endcase
  end

  always @(posedge clk) begin
    if (dp_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'(i * 5 + 3);
      r1 <= 4'h0;
      r2 <= 4'h0;
      r3 <= 4'h0;
    end else begin
      if (reg_en[0]) r1 <= in_sel ? bus : sw;
      if (reg_en[1]) r2 <= bus;
      if (reg_en[2]) r3 <= bus;
      if (ram_wen) ram[ram_addr] <= bus;
    end
  end

  // Command-level model: a queue of expected per-cycle outputs
  typedef struct packed {
    logic       rdy;
    logic [1:0] bs;
    logic       ins;
    logic [2:0] en;
    logic       wen;
    logic [3:0] a;
    logic       dn;
    logic       er;
  } exp_t;

  exp_t q[$];
  localparam exp_t IDLE_EXP = 14'b1_00_0_000_0_0000_0_0;

  function automatic exp_t ctl(input logic [1:0] bs, input logic ins,
                               input logic [2:0] en, input logic wen,
                               input logic [3:0] a);
    exp_t e;
    e = '0;
    e.bs = bs;
    e.ins = ins;
    e.en = en;
    e.wen = wen;
    e.a = a;
    return e;
  endfunction

  function automatic void push_cmd();
    exp_t fin;
    logic bad;
    logic [2:0] oh;
    bad = (cmd_op > 3'd5) ||
          ((cmd_op == 3'd2 || cmd_op == 3'd4) && cmd_dst == 2'd3) ||
          (cmd_op == 3'd5 && cmd_len == 4'd0);
    oh = 3'(3'b001 << cmd_dst);
    fin = '0;
    fin.dn = 1'b1;
    fin.er = bad;
    if (bad || cmd_op == 3'd0) begin
      q.push_back(ctl(2'd0, 1'b0, 3'b000, 1'b0, 4'd0));
    end else if (cmd_op == 3'd5) begin
      for (int j = 0; j < int'(cmd_len); j++) begin
        q.push_back(ctl(2'd3, 1'b0, 3'b010, 1'b0, 4'(cmd_addr + 4'(j))));
        q.push_back(ctl(2'd1, 1'b0, 3'b000, 1'b1, 4'(cmd_addr2 + 4'(j))));
      end
    end else begin
      case (cmd_op)
        3'd1: q.push_back(ctl(2'd0, 1'b0, 3'b001, 1'b0, 4'd0));
        3'd2: q.push_back(ctl(cmd_src, cmd_dst == 2'd0, oh, 1'b0,
                              cmd_src == 2'd3 ? cmd_addr : 4'd0));
        3'd3: q.push_back(ctl(cmd_src, 1'b0, 3'b000, 1'b1, cmd_addr));
        default: q.push_back(ctl(2'd3, cmd_dst == 2'd0, oh, 1'b0, cmd_addr));
      endcase
    end
    q.push_back(fin);
  endfunction

  always @(posedge clk) begin
    if (rst) q.delete();
    else if (q.size() != 0) void'(q.pop_front());
    else if (cmd_valid) push_cmd();
  end

  int nvec = 0;
  int nbad = 0;
  int cyc = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] src,
                       input logic [1:0] dst, input logic [3:0] a,
                       input logic [3:0] a2, input logic [3:0] len);
    logic got;
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_addr = a;
    cmd_addr2 = a2;
    cmd_len = len;
    cmd_valid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = cmd_ready;
    end
    check("accept_timeout", 16'(got), 16'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic e);
    logic seen;
    seen = 1'b0;
    lat = 0;
    e = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1'b1;
        e = err;
      end
    end
    check("done_timeout", 16'(seen), 16'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] src,
                     input logic [1:0] dst, input logic [3:0] a,
                     input logic [3:0] a2, input logic [3:0] len,
                     input int exp_lat, input logic exp_err);
    int lat;
    logic e;
    issue(op, src, dst, a, a2, len);
    wait_done(lat, e);
    check("done_latency", 16'(lat), 16'(exp_lat));
    check("err_flag", 16'(e), 16'(exp_err));
  endtask

  logic [3:0] snap [16];
  int t_acc [4];
  logic saw_done;

  initial begin
    rst = 1'b1;
    dp_init = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 3'd0;
    cmd_src = 2'd0;
    cmd_dst = 2'd0;
    cmd_addr = 4'd0;
    cmd_addr2 = 4'd0;
    cmd_len = 4'd0;
    sw = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    dp_init = 1'b0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        nvec++;
        if ({cmd_ready, bus_sel, in_sel, reg_en, ram_wen, ram_addr, done, err}
            !== (q.size() != 0 ? q[0] : IDLE_EXP)) begin
          nbad++;
          $display("FAIL cycle %0d: got %b expected %b", cyc,
                   {cmd_ready, bus_sel, in_sel, reg_en, ram_wen, ram_addr,
                    done, err},
                   q.size() != 0 ? q[0] : IDLE_EXP);
        end
      end
    join_none

    @(negedge clk);
    check("reset_ready", 16'(cmd_ready), 16'd1);
    check("reset_ctrl",
          16'({bus_sel, in_sel, reg_en, ram_wen, ram_addr, done, err}),
          16'd0);

    sw = 4'hA;
    run(3'd1, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2, 1'b0);
    check("ldext_r1", 16'(r1), 16'hA);

    sw = 4'h5;
    run(3'd1, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2, 1'b0);
    run(3'd2, 2'd0, 2'd2, 4'd0, 4'd0, 4'd0, 2, 1'b0);
    check("mov_r3", 16'(r3), 16'h5);
    run(3'd3, 2'd2, 2'd0, 4'd7, 4'd0, 4'd0, 2, 1'b0);
    check("st_ram7", 16'(ram[7]), 16'h5);
    run(3'd4, 2'd0, 2'd1, 4'd7, 4'd0, 4'd0, 2, 1'b0);
    check("ld_r2", 16'(r2), 16'h5);
    run(3'd2, 2'd3, 2'd0, 4'd9, 4'd0, 4'd0, 2, 1'b0);
    check("mov_ram_r1", 16'(r1), 16'h0);
    run(3'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2, 1'b0);

    run(3'd5, 2'd0, 2'd0, 4'd14, 4'd2, 4'd3, 7, 1'b0);
    check("bcopy_ram2", 16'(ram[2]), 16'h9);
    check("bcopy_ram3", 16'(ram[3]), 16'hE);
    check("bcopy_ram4", 16'(ram[4]), 16'h3);

    run(3'd7, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2, 1'b1);
    run(3'd2, 2'd1, 2'd3, 4'd0, 4'd0, 4'd0, 2, 1'b1);
    run(3'd5, 2'd0, 2'd0, 4'd1, 4'd5, 4'd0, 2, 1'b1);
    run(3'd4, 2'd0, 2'd3, 4'd1, 4'd0, 4'd0, 2, 1'b1);

    for (int i = 0; i < 16; i++) snap[i] = ram[i];
    issue(3'd5, 2'd0, 2'd0, 4'd8, 4'd12, 4'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    check("abort_no_done", 16'(saw_done), 16'd0);
    check("abort_ram12", 16'(ram[12]), 16'hB);
    check("abort_ram13", 16'(ram[13]), 16'(snap[13]));
    check("abort_ram14", 16'(ram[14]), 16'(snap[14]));
    check("abort_ram15", 16'(ram[15]), 16'(snap[15]));

    sw = 4'hC;
    run(3'd1, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 2, 1'b0);

    cmd_op = 3'd2;
    cmd_src = 2'd0;
    cmd_dst = 2'd1;
    cmd_addr = 4'd0;
    cmd_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      logic got;
      got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        got = cmd_ready;
      end
      check("b2b_accept", 16'(got), 16'd1);
      t_acc[j] = cyc;
      @(posedge clk);
      #1;
      if (j == 3) begin
        cmd_valid = 1'b0;
      end else begin
        cmd_op = 3'd5;
        cmd_src = 2'd3;
        cmd_dst = 2'd3;
        cmd_addr = 4'hF;
        cmd_len = 4'd0;
        @(posedge clk);
        #1;
        cmd_op = 3'd2;
        case (j)
          0: begin cmd_src = 2'd1; cmd_dst = 2'd2; cmd_addr = 4'd0; end
          1: begin cmd_src = 2'd3; cmd_dst = 2'd0; cmd_addr = 4'd2; end
          default: begin cmd_src = 2'd0; cmd_dst = 2'd1; cmd_addr = 4'd0; end
        endcase
      end
    end
    for (int j = 1; j < 4; j++)
      check("b2b_interval", 16'(t_acc[j] - t_acc[j-1]), 16'd3);
    begin
      int lat;
      logic e;
      wait_done(lat, e);
    end
    check("b2b_r2", 16'(r2), 16'h9);
    check("b2b_r3", 16'(r3), 16'hC);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
